// File: rtl/maj_pc_reconstruct.sv
// -----------------------------------------------------------------------------
// maj_pc_reconstruct
//
// Rebuilds a PC_NUM-element feature-space vector from a MAJ_PC_NUM-element
// major-PC score vector:
//
//   out_vector[j] = sat( (sum_i score_vector[i] * basis[i][j]) >>> FRAC_BITS )
//
// This is the transpose product of the projection stage. Operands are signed
// two's-complement Q-format words sharing FRAC_BITS fractional bits. One
// multiply-accumulate is performed per clock. The inner loop walks i (score
// index) and the outer loop walks j (output element), so each output element
// is finished and written after MAJ_PC_NUM cycles, in index order.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds its payload stable while
// valid is high and not yet accepted. Valid never depends on ready.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   in_valid      score vector present
//   in_ready      block can accept a score vector (high only in IDLE)
//   score_vector  MAJ_PC_NUM signed words, element i at [i*FP_SIZE +: FP_SIZE]
//   basis         MAJ_PC_NUM x PC_NUM signed words, element (i,j) at
//                 [(i*PC_NUM+j)*FP_SIZE +: FP_SIZE]; held stable by the
//                 source from accept until out_valid
//   out_valid     out_vector holds a complete result (DONE state)
//   out_ready     consumer takes the result
//   out_vector    PC_NUM signed words, element j at [j*FP_SIZE +: FP_SIZE]
//   sat_flag      at least one element of the current result was clamped
// -----------------------------------------------------------------------------
module maj_pc_reconstruct #(
  parameter int FP_SIZE    = 64,
  parameter int PC_NUM     = 32,
  parameter int MAJ_PC_NUM = 10,
  parameter int FRAC_BITS  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [MAJ_PC_NUM*FP_SIZE-1:0]         score_vector,
  input  logic [MAJ_PC_NUM*PC_NUM*FP_SIZE-1:0]  basis,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PC_NUM*FP_SIZE-1:0]             out_vector,
  output logic                                  sat_flag
);

  // Full-precision product, and an accumulator wide enough that the sum of
  // MAJ_PC_NUM products can never wrap.
  localparam int PROD_W = 2 * FP_SIZE;
  localparam int ACC_W  = 2 * FP_SIZE + $clog2(MAJ_PC_NUM) + 1;
  localparam int I_W    = (MAJ_PC_NUM > 1) ? $clog2(MAJ_PC_NUM) : 1;
  localparam int J_W    = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;

  localparam logic [I_W-1:0] I_LAST = I_W'(MAJ_PC_NUM - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(PC_NUM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched scores and result registers
  logic [FP_SIZE-1:0]       score_q [MAJ_PC_NUM];
  logic [FP_SIZE-1:0]       out_q   [PC_NUM];
  logic                     sat_q;

  // Loop counters and accumulator
  logic [I_W-1:0]           i_cnt;
  logic [J_W-1:0]           j_cnt;
  logic signed [ACC_W-1:0]  acc;

  // Basis viewed as a 2-D array so the MAC operand mux indexes it directly
  logic [FP_SIZE-1:0]       basis_arr [MAJ_PC_NUM][PC_NUM];

  // Datapath combinational signals
  logic [FP_SIZE-1:0]       s_sel;
  logic [FP_SIZE-1:0]       b_sel;
  logic [PROD_W-1:0]        s_ext;
  logic [PROD_W-1:0]        b_ext;
  logic [PROD_W-1:0]        prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-FP_SIZE:0]   hi_bits;
  logic                     ovf;
  logic [FP_SIZE-1:0]       elem_val;

  // Control strobes
  logic                     accept;
  logic                     last_mac;
  logic                     last_elem;

  // ---------------------------------------------------------------------------
  // Unpack the flat basis bus
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < MAJ_PC_NUM; gi++) begin : g_basis_row
    for (genvar gj = 0; gj < PC_NUM; gj++) begin : g_basis_col
      assign basis_arr[gi][gj] = basis[(gi*PC_NUM+gj)*FP_SIZE +: FP_SIZE];
    end
  end

  // ---------------------------------------------------------------------------
  // Pack the result registers onto the flat output bus
  // ---------------------------------------------------------------------------
  for (genvar gk = 0; gk < PC_NUM; gk++) begin : g_out_pack
    assign out_vector[gk*FP_SIZE +: FP_SIZE] = out_q[gk];
  end

  assign sat_flag = sat_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (last_mac && last_elem) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_mac  = (i_cnt == I_LAST);
  assign last_elem = (j_cnt == J_LAST);

  // ---------------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    s_sel = score_q[i_cnt];
    b_sel = basis_arr[i_cnt][j_cnt];

    // Sign-extend both operands to the product width; the low PROD_W bits of
    // that product are the exact signed product.
    s_ext = {{FP_SIZE{s_sel[FP_SIZE-1]}}, s_sel};
    b_ext = {{FP_SIZE{b_sel[FP_SIZE-1]}}, b_sel};
    prod  = s_ext * b_ext;

    acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Arithmetic shift rounds toward -infinity (floor).
    shifted = acc_next >>> FRAC_BITS;

    // The value fits in FP_SIZE bits only if every bit from the FP_SIZE-1
    // position upward equals the sign bit.
    hi_bits = shifted[ACC_W-1:FP_SIZE-1];
    ovf     = !((&hi_bits) || (~|hi_bits));

    if (!ovf) begin
      elem_val = shifted[FP_SIZE-1:0];
    end else if (shifted[ACC_W-1]) begin
      elem_val = {1'b1, {(FP_SIZE-1){1'b0}}};
    end else begin
      elem_val = {1'b0, {(FP_SIZE-1){1'b1}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      sat_q <= 1'b0;
      for (int k = 0; k < MAJ_PC_NUM; k++) begin
        score_q[k] <= '0;
      end
      for (int k = 0; k < PC_NUM; k++) begin
        out_q[k] <= '0;
      end
    end else if (accept) begin
      // Scores are captured here so later changes on the input are harmless.
      for (int k = 0; k < MAJ_PC_NUM; k++) begin
        score_q[k] <= score_vector[k*FP_SIZE +: FP_SIZE];
      end
      acc   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      sat_q <= 1'b0;
    end else if (state == COMPUTE) begin
      if (last_mac) begin
        out_q[j_cnt] <= elem_val;
        if (ovf) begin
          sat_q <= 1'b1;
        end
        acc   <= '0;
        i_cnt <= '0;
        // Wraps to zero after the final element; it is cleared on the next
        // accept regardless.
        j_cnt <= j_cnt + 1'b1;
      end else begin
        acc   <= acc_next;
        i_cnt <= i_cnt + 1'b1;
      end
    end
  end

endmodule
